rv32i_mc_ctrl: RTL
==================

Name: rv32i_mc_ctrl

Overview:
Multicycle sequencer for the RV32I integrated datapath. It steps each instruction through fetch, decode, execute and optional memory phases. It drives the datapath's mux selects, ALUControl and ImmSrc, and gates every architectural write (PC, register file, dmem) to a single commit cycle. It adds a ready handshake toward dmem so slow memory inserts wait states, plus a sticky trap on illegal opcodes or memory timeout.

Parameters:
MEM_TIMEOUT, 16, maximum MEM-state cycles without mem_ready before a bus-error trap (>=1)
CNT_W, 5, width of the wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
Instr  in  32  current instruction (opcode, funct3, funct7[5])
nzcv  in  4  ALU flags {N,Z,C,V}; C=1 means no borrow on SUB
mem_ready  in  1  dmem completes the current access this cycle
IRWrite  out  1  latch imem output into the instruction register
PCWrite  out  1  PC register load enable
RegWrite  out  1  register file write enable
MemWrite  out  1  store strobe to dmem, valid with mem_req
mem_req  out  1  dmem access request (load or store)
PCSrc  out  2  00 PC+4, 01 PC_target, 10 ALUResult
ResultSrc  out  2  00 ALUResult, 01 load data, 10 PC+4
ALUSrcA  out  2  00 rs1, 01 PC, 10 zero
ALUSrcB  out  1  0 rs2, 1 ImmExt
ImmSrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J
ALUControl  out  5  ALU op code (package constants)
trap  out  1  sticky: illegal opcode or memory timeout
trap_cause  out  2  00 none, 01 illegal opcode, 10 dmem timeout
instret  out  32  retired-instruction count (optional feature)

Behaviour:
- Reset (rst=1 at edge): state FETCH, wait counter 0, trap=0, trap_cause=00, instret=0. All enables/strobes are 0 while rst is high; selects are 0.
- States: FETCH, DECODE, EXEC, MEM, TRAP. Outputs are a Moore/Mealy mix; strobes are combinational from state, Instr and mem_ready.
- FETCH: IRWrite=1 for one cycle -> DECODE.
- DECODE: decode opcode. Legal -> EXEC. Illegal -> TRAP, cause 01. Legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
- EXEC, non-memory ops, are the commit cycle: PCWrite=1 -> FETCH. Selects per op:
  - R/I-ALU: ALUSrcA=00, ALUSrcB per type, ResultSrc=00, RegWrite=1, PCSrc=00.
  - LUI: ALUSrcA=10, ImmSrc=011, ALU ADD, RegWrite=1.
  - AUIPC: ALUSrcA=01, ImmSrc=011, ALU ADD, RegWrite=1.
  - JAL: ImmSrc=100, PCSrc=01, ResultSrc=10, RegWrite=1.
  - JALR: ALUSrcA=00, ALUSrcB=1, ALU ADD, PCSrc=10, ResultSrc=10, RegWrite=1. No LSB masking.
  - Branch: ALU SUB, ImmSrc=010, RegWrite=0. PCSrc=01 if taken, else 00.
- Branch conditions by funct3: 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 !C; 111 C. funct3 010/011 -> TRAP cause 01.
- EXEC, load/store: address calc only (ALUSrcA=00, ALUSrcB=1, ALU ADD, ImmSrc I or S). No strobes. -> MEM.
- MEM: mem_req=1 and MemWrite=1 for stores; address selects held from EXEC. Counter increments each cycle mem_ready=0.
  - mem_ready=1 is the commit cycle: PCWrite=1; loads also RegWrite=1 with ResultSrc=01 -> FETCH, counter cleared.
  - Counter reaching MEM_TIMEOUT with mem_ready still 0 -> TRAP, cause 10. No commit.
  - mem_ready arriving in the same cycle as timeout: ready wins and commits.
- TRAP: all enables 0, trap=1, holds until rst.
- ALU decode: R-type uses funct7[5] to select SUB/SRA. I-type uses funct7[5] only for shifts (SRAI); ADDI never subtracts.
- Exactly one PCWrite pulse per retired instruction. RegWrite is never asserted outside a commit cycle.
- Reset mid-MEM: request drops in the reset cycle; no commit occurs.

Optional Feature:
RV32I_CTRL_PERF_EN
- Defined: instret increments by 1 in every commit cycle and wraps at 2^32. It resets to 0 and freezes in TRAP.
- Undefined: instret is tied to 0 and no counter flops are built.

Decomposition:
- Package rv32i_ctrl_pkg holds:
  - opcode constants
  - ALUControl codes: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLL 00101, SRL 00110, SRA 00111, SLT 01000, SLTU 01001
  - ImmSrc, PCSrc, ResultSrc, ALUSrcA encodings
  - state enum and trap_cause codes
- One combinational sub-module, rv32i_alu_dec: inputs opcode class, funct3, funct7[5]; output ALUControl.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with mem_ready=0 -> IRWrite in cycle 1, commit in cycle 3 (RegWrite=1, PCWrite=1, ALUControl=00000, ALUSrcB=1), back to FETCH.
- BEQ with nzcv=0100 -> PCSrc=01 at commit. Same instruction with nzcv=0000 -> PCSrc=00. RegWrite=0 in both cases.
- LW (0x0000A103) with mem_ready raised after 3 wait cycles -> mem_req held 4 cycles, single RegWrite with ResultSrc=01 on the ready cycle, one PCWrite.
- SW with mem_ready never asserted, MEM_TIMEOUT=16 -> after 16 MEM cycles trap=1, cause 10, MemWrite/PCWrite drop to 0, stays until rst.
- Opcode 0x0000007F -> TRAP cause 01 from DECODE. Then rst=1 for one cycle -> trap=0, state FETCH.
- With RV32I_CTRL_PERF_EN: 10 mixed instructions retired -> instret=10. Without the macro -> instret=0 throughout.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle sequencer: opcodes, ALU op codes,
// datapath select encodings, FSM states and trap causes.
package rv32i_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SRL  = 5'b00110;
    localparam logic [4:0] ALU_SRA  = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_ALU    = 2'b10;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_TRAP
    } state_e;

    // ALU_CLS_ADD covers every op that only needs an address/offset sum.
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_R,
        ALU_CLS_I
    } alu_cls_e;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal_op = 1'b1;
            default:                           is_legal_op = 1'b0;
        endcase
    endfunction

    // Flags are {N,Z,C,V}; C=1 means no borrow on SUB.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic [3:0] flags);
        case (funct3)
            3'b000:  branch_taken = flags[2];
            3'b001:  branch_taken = ~flags[2];
            3'b100:  branch_taken = flags[3] ^ flags[0];
            3'b101:  branch_taken = ~(flags[3] ^ flags[0]);
            3'b110:  branch_taken = ~flags[1];
            3'b111:  branch_taken = flags[1];
            default: branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_alu_dec.sv
// Combinational ALU op decoder: maps opcode class, funct3 and funct7[5]
// to the ALUControl code.
module rv32i_alu_dec
    import rv32i_ctrl_pkg::*;
(
    input  alu_cls_e   i_cls,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [4:0] o_alu_ctrl
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_cls)
            ALU_CLS_ADD: o_alu_ctrl = ALU_ADD;
            ALU_CLS_SUB: o_alu_ctrl = ALU_SUB;
            default: begin
                case (i_funct3)
                    // funct7[5] is part of the immediate for ADDI, so only R-type subtracts
                    3'b000:  o_alu_ctrl = (i_cls == ALU_CLS_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_alu_ctrl = ALU_SLL;
                    3'b010:  o_alu_ctrl = ALU_SLT;
                    3'b011:  o_alu_ctrl = ALU_SLTU;
                    3'b100:  o_alu_ctrl = ALU_XOR;
                    3'b101:  o_alu_ctrl = i_funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  o_alu_ctrl = ALU_OR;
                    default: o_alu_ctrl = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multicycle RV32I sequencer with dmem ready handshake and sticky trap.
// Define RV32I_CTRL_PERF_EN to build the retired-instruction counter.
module rv32i_mc_ctrl
    import rv32i_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic [3:0]  nzcv,
    input  logic        mem_ready,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        mem_req,
    output logic [1:0]  PCSrc,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic        ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic [4:0]  ALUControl,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_trap;
    logic [1:0]       r_cause;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7b5;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_legal;
    logic       w_mem_timeout;
    logic [4:0] w_alu_ctrl;
    alu_cls_e   w_cls;
    logic       w_unused;

    assign w_opcode   = Instr[6:0];
    assign w_funct3   = Instr[14:12];
    assign w_funct7b5 = Instr[30];
    assign w_unused   = &{1'b0, Instr[31], Instr[29:15], Instr[11:7]};
    assign w_is_load  = (w_opcode == OP_LOAD);
    assign w_is_store = (w_opcode == OP_STORE);

    // Branch funct3 010/011 are unassigned encodings and trap like a bad opcode.
    assign w_legal = is_legal_op(w_opcode) &&
                     !(w_opcode == OP_BRANCH && w_funct3[2:1] == 2'b01);

    assign w_mem_timeout = !mem_ready && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        w_cls = ALU_CLS_ADD;
        case (w_opcode)
            OP_R:      w_cls = ALU_CLS_R;
            OP_I:      w_cls = ALU_CLS_I;
            OP_BRANCH: w_cls = ALU_CLS_SUB;
            default:   w_cls = ALU_CLS_ADD;
        endcase
    end

    rv32i_alu_dec u_alu_dec (
        .i_cls      (w_cls),
        .i_funct3   (w_funct3),
        .i_funct7b5 (w_funct7b5),
        .o_alu_ctrl (w_alu_ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_cnt   <= '0;
            r_trap  <= 1'b0;
            r_cause <= CAUSE_NONE;
        end else begin
            case (r_state)
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    if (w_legal) begin
                        r_state <= ST_EXEC;
                    end else begin
                        r_state <= ST_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= CAUSE_ILLEGAL;
                    end
                end
                ST_EXEC: begin
                    r_cnt   <= '0;
                    r_state <= (w_is_load || w_is_store) ? ST_MEM : ST_FETCH;
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        r_state <= ST_FETCH;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_mem_timeout) begin
                            r_state <= ST_TRAP;
                            r_trap  <= 1'b1;
                            r_cause <= CAUSE_TIMEOUT;
                        end
                    end
                end
                ST_TRAP: r_state <= ST_TRAP;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // Strobes and selects; everything is forced to zero while rst is high.
    always_comb begin
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        mem_req    = 1'b0;
        PCSrc      = PCSRC_PC4;
        ResultSrc  = RES_ALU;
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = 1'b0;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        if (!rst) begin
            case (r_state)
                ST_FETCH: IRWrite = 1'b1;
                ST_EXEC: begin
                    ALUControl = w_alu_ctrl;
                    case (w_opcode)
                        OP_R: begin
                            RegWrite = 1'b1;
                            PCWrite  = 1'b1;
                        end
                        OP_I: begin
                            ALUSrcB  = 1'b1;
                            RegWrite = 1'b1;
                            PCWrite  = 1'b1;
                        end
                        OP_LUI, OP_AUIPC: begin
                            ALUSrcA  = (w_opcode == OP_LUI) ? SRCA_ZERO : SRCA_PC;
                            ALUSrcB  = 1'b1;
                            ImmSrc   = IMM_U;
                            RegWrite = 1'b1;
                            PCWrite  = 1'b1;
                        end
                        OP_JAL: begin
                            ImmSrc    = IMM_J;
                            PCSrc     = PCSRC_TARGET;
                            ResultSrc = RES_PC4;
                            RegWrite  = 1'b1;
                            PCWrite   = 1'b1;
                        end
                        OP_JALR: begin
                            ALUSrcB   = 1'b1;
                            PCSrc     = PCSRC_ALU;
                            ResultSrc = RES_PC4;
                            RegWrite  = 1'b1;
                            PCWrite   = 1'b1;
                        end
                        OP_BRANCH: begin
                            ImmSrc  = IMM_B;
                            PCWrite = 1'b1;
                            PCSrc   = branch_taken(w_funct3, nzcv) ? PCSRC_TARGET : PCSRC_PC4;
                        end
                        OP_LOAD, OP_STORE: begin
                            ALUSrcB = 1'b1;
                            ImmSrc  = w_is_store ? IMM_S : IMM_I;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    ALUControl = w_alu_ctrl;
                    ALUSrcB    = 1'b1;
                    ImmSrc     = w_is_store ? IMM_S : IMM_I;
                    mem_req    = 1'b1;
                    MemWrite   = w_is_store;
                    if (mem_ready) begin
                        PCWrite = 1'b1;
                        if (w_is_load) begin
                            RegWrite  = 1'b1;
                            ResultSrc = RES_LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign trap       = r_trap;
    assign trap_cause = r_cause;

`ifdef RV32I_CTRL_PERF_EN
    logic [31:0] r_instret;

    // PCWrite fires exactly once per retired instruction and never in TRAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (PCWrite) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

endmodule
